// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional FETCH_PERF_EN macro adds perf counters to fetch_unit.
package fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc_n;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/grant + in-order response bus.
// master = fetch side, slave = instruction cache side.
interface fetch_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc_n, inst}, sync clear.
// Head reads as zero when the queue is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  fetch_entry_t             i_wdata,
  output fetch_entry_t             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_count = r_cnt;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC generation, credit-limited fetch, prefetch queue, redirect.
// Define FETCH_PERF_EN to add perf_fetched/perf_squashed/perf_stall.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  fetch_if.master           imem,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_pc_n,
  output logic [INST_W-1:0] if_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIM = DEPTH[CW:0];

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;
  logic            w_empty;
  logic            w_full;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_inflight;
  logic            w_req;
  logic            w_fire;
  logic            w_rv_ok;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_inc;
  logic [CW-1:0]   w_dec;

  // queued + in-flight never exceeds DEPTH, so every kept response fits
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_req      = !rst && !redirect && (w_inflight < LIM);
  assign w_fire     = w_req && imem.imem_gnt;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign w_rv_ok = imem.imem_rvalid && (r_outstanding != '0);
  assign w_drop  = (r_discard != '0);
  assign w_push  = w_rv_ok && !w_drop && !redirect;

  assign if_valid = !rst && !w_empty;
  assign w_pop    = if_valid && id_ready && !redirect;
  assign if_pc_n  = if_valid ? w_head.pc_n : '0;
  assign if_inst  = if_valid ? w_head.inst : '0;

  assign w_inc   = {{(CW-1){1'b0}}, w_fire};
  assign w_dec   = {{(CW-1){1'b0}}, w_rv_ok};
  assign w_wdata = '{pc_n: r_resp_pc + PC_STEP, inst: imem.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect) begin
      // everything still in flight belongs to the old path
      r_pc          <= word_align(redirect_pc);
      r_resp_pc     <= word_align(redirect_pc);
      r_outstanding <= r_outstanding - w_dec;
      r_discard     <= r_outstanding - w_dec;
    end else begin
      if (w_fire) r_pc <= r_pc + PC_STEP;
      if (w_push) r_resp_pc <= r_resp_pc + PC_STEP;
      r_outstanding <= r_outstanding + w_inc - w_dec;
      if (w_rv_ok && w_drop) r_discard <= r_discard - 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched  <= '0;
      r_perf_squashed <= '0;
      r_perf_stall    <= '0;
    end else begin
      if (w_push && r_perf_fetched != '1)
        r_perf_fetched <= r_perf_fetched + 1'b1;
      if (w_rv_ok && (w_drop || redirect) && r_perf_squashed != '1)
        r_perf_squashed <= r_perf_squashed + 1'b1;
      if (if_valid && !id_ready && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
  assign perf_stall    = r_perf_stall;
`endif

  a_rvalid_credit: assert property (
    @(posedge clk) disable iff (rst)
    imem.imem_rvalid |-> (r_outstanding != '0));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    (w_push && w_full) |-> w_pop);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, expected-queue scoreboard,
// directed vector tables and corner-case sequences.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pcn;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        gnt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pcn;
    logic [31:0] e_inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnt, rdy, redir, rv, rv2;
  logic [31:0] rpc, rd, rd2;

  logic        s_req, s_valid, s2_req, s2_valid;
  logic [31:0] s_addr, s_pcn, s_inst;
  logic [31:0] s2_addr, s2_pcn, s2_inst;

  logic        w_v1, w_v2;
  logic [31:0] w_pcn1, w_inst1, w_pcn2, w_inst2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int epoch = 0;
  logic [31:0] pc_m;

  pend_t pend[$];
  exp_t  expq[$];

  vec_t t1[6];
  vec_t t5[5];

  fetch_if m1 ();
  fetch_if m2 ();

  assign m1.imem_gnt    = gnt;
  assign m1.imem_rvalid = rv;
  assign m1.imem_rdata  = rd;
  assign m2.imem_gnt    = gnt;
  assign m2.imem_rvalid = rv2;
  assign m2.imem_rdata  = rd2;

`ifdef FETCH_PERF_EN
  logic [31:0] pf1, ps1, pt1, pf2, ps2, pt2;
`endif

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (m1),
    .redirect    (redir),
    .redirect_pc (rpc),
    .id_ready    (rdy),
    .if_valid    (w_v1),
    .if_pc_n     (w_pcn1),
    .if_inst     (w_inst1)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (pf1),
    .perf_squashed (ps1),
    .perf_stall    (pt1)
`endif
  );

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .imem        (m2),
    .redirect    (redir),
    .redirect_pc (rpc),
    .id_ready    (rdy),
    .if_valid    (w_v2),
    .if_pc_n     (w_pcn2),
    .if_inst     (w_inst2)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (pf2),
    .perf_squashed (ps2),
    .perf_stall    (pt2)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // one clock: drive memory, sample, check, update model, advance
  task automatic tick();
    exp_t  e;
    pend_t p;
    logic  e_req;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rd = f(pend[0].addr);
    end else begin
      rv = 1'b0;
      rd = 32'h0;
    end
    #1;
    s_req    = m1.imem_req;
    s_addr   = m1.imem_addr;
    s_valid  = w_v1;
    s_pcn    = w_pcn1;
    s_inst   = w_inst1;
    s2_req   = m2.imem_req;
    s2_addr  = m2.imem_addr;
    s2_valid = w_v2;
    s2_pcn   = w_pcn2;
    s2_inst  = w_inst2;

    e_req = !redir && ((expq.size() + pend.size()) < DEPTH);
    chk("sb_req", {31'b0, s_req}, {31'b0, e_req});
    if (s_req) chk("sb_addr", s_addr, pc_m);
    chk("sb_valid", {31'b0, s_valid}, {31'b0, expq.size() != 0});
    if (expq.size() != 0) begin
      chk("sb_pc_n", s_pcn, expq[0].pcn);
      chk("sb_inst", s_inst, expq[0].inst);
    end else begin
      chk("sb_pc_n_empty", s_pcn, 32'h0);
      chk("sb_inst_empty", s_inst, 32'h0);
    end

    if (s_valid && rdy && !redir && expq.size() != 0) e = expq.pop_front();
    if (rv) begin
      p = pend.pop_front();
      if (!redir && p.ep == epoch) begin
        e.pcn  = p.addr + 32'd4;
        e.inst = f(p.addr);
        expq.push_back(e);
      end
    end
    if (s_req && gnt) begin
      p.addr = s_addr;
      p.ep   = epoch;
      p.due  = cyc + lat;
      pend.push_back(p);
      pc_m = s_addr + 32'd4;
    end
    if (redir) begin
      expq.delete();
      pc_m  = {rpc[31:2], 2'b00};
      epoch = epoch + 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    redir = 1'b0;
    gnt   = 1'b0;
    rdy   = 1'b0;
    rv    = 1'b0;
    rv2   = 1'b0;
    rd    = 32'h0;
    rd2   = 32'h0;
    rpc   = 32'h0;
    #1;
    chk("rst_req", {31'b0, m1.imem_req}, 32'h0);
    chk("rst_valid", {31'b0, w_v1}, 32'h0);
    chk("rst_pc_n", w_pcn1, 32'h0);
    chk("rst_inst", w_inst1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid_held", {31'b0, w_v1}, 32'h0);
    chk("rst_req2", {31'b0, m2.imem_req}, 32'h0);
    rst = 1'b0;
    pc_m = 32'h0;
    pend.delete();
    expq.delete();
    epoch = epoch + 1;
    cyc++;
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!s_valid && k < 30);
    if (!s_valid) timeout(nm);
  endtask

  task automatic test3();
    int k;
    gnt = 1'b0;
    rdy = 1'b1;
    k = 0;
    while ((pend.size() != 0 || expq.size() != 0) && k < 40) begin
      tick();
      k++;
    end
    if (k >= 40) timeout("t3_drain");
    lat = 4;
    gnt = 1'b1;
    repeat (3) tick();
    redir = 1'b1;
    rpc   = 32'h0000_0103;
    tick();
    chk("t3_req_low", {31'b0, s_req}, 32'h0);
    redir = 1'b0;
    wait_valid("t3_wait");
    chk("t3_pc_n", s_pcn, 32'h104);
    chk("t3_inst", s_inst, f(32'h100));
  endtask

  task automatic test2();
    lat = 1;
    gnt = 1'b1;
    rdy = 1'b0;
    wait_valid("t2_wait");
    repeat (9) tick();
    chk("t2_req_low", {31'b0, s_req}, 32'h0);
    chk("t2_valid_held", {31'b0, s_valid}, 32'h1);
    gnt = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_drain_valid", {31'b0, s_valid}, 32'h1);
    end
    tick();
    chk("t2_drained", {31'b0, s_valid}, 32'h0);
    gnt = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t1[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0};
    t1[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0};
    t1[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 32'hA500_0013};
    t1[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'hA500_0017};
    t1[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, 32'hA500_001B};
    t1[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 32'hA500_001F};

    t5[0] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0};
    t5[1] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
    t5[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1,
              32'hFFFF_FFFC, 32'h5AFF_FFEB};
    t5[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1,
              32'h0000_0000, 32'h5AFF_FFEF};
    t5[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1,
              32'h0000_0004, 32'hA500_0013};

    do_reset();

    lat = 1;
    for (int i = 0; i < 6; i++) begin
      gnt = t1[i].gnt;
      rdy = t1[i].rdy;
      tick();
      chk("t1_req", {31'b0, s_req}, {31'b0, t1[i].e_req});
      if (t1[i].e_req) chk("t1_addr", s_addr, t1[i].e_addr);
      chk("t1_valid", {31'b0, s_valid}, {31'b0, t1[i].e_valid});
      if (t1[i].e_valid) begin
        chk("t1_pc_n", s_pcn, t1[i].e_pcn);
        chk("t1_inst", s_inst, t1[i].e_inst);
      end
    end
    repeat (6) tick();

    test3();
    test2();

    lat = 1;
    gnt = 1'b1;
    rdy = 1'b1;
    repeat (4) tick();
    redir = 1'b1;
    rpc   = 32'h0000_0200;
    tick();
    chk("t4_req_low", {31'b0, s_req}, 32'h0);
    chk("t4_valid_before", {31'b0, s_valid}, 32'h1);
    redir = 1'b0;
    tick();
    chk("t4_flushed", {31'b0, s_valid}, 32'h0);
    chk("t4_req", {31'b0, s_req}, 32'h1);
    chk("t4_addr", s_addr, 32'h200);
    repeat (5) tick();

    redir = 1'b1;
    rpc   = 32'h0000_0300;
    tick();
    rpc   = 32'h0000_0404;
    tick();
    redir = 1'b0;
    wait_valid("b2b_wait");
    chk("b2b_pc_n", s_pcn, 32'h408);
    chk("b2b_inst", s_inst, f(32'h404));
    repeat (4) tick();

    do_reset();
    lat = 1;
    begin
      logic        p2v;
      logic [31:0] p2a;
      p2v = 1'b0;
      p2a = 32'h0;
      for (int i = 0; i < 5; i++) begin
        gnt = t5[i].gnt;
        rdy = t5[i].rdy;
        rv2 = p2v;
        rd2 = f(p2a);
        tick();
        chk("t5_req", {31'b0, s2_req}, {31'b0, t5[i].e_req});
        if (t5[i].e_req) chk("t5_addr", s2_addr, t5[i].e_addr);
        chk("t5_valid", {31'b0, s2_valid}, {31'b0, t5[i].e_valid});
        if (t5[i].e_valid) begin
          chk("t5_pc_n", s2_pcn, t5[i].e_pcn);
          chk("t5_inst", s2_inst, t5[i].e_inst);
        end
        p2v = s2_req && gnt;
        p2a = s2_addr;
      end
      rv2 = 1'b0;
    end

`ifdef FETCH_PERF_EN
    do_reset();
    test3();
    test2();
    chk("perf_squashed", ps1, 32'd3);
    chk("perf_stall", pt1, 32'd10);
    do_reset();
    chk("perf_fetched_rst", pf1, 32'h0);
    chk("perf_squashed_rst", ps1, 32'h0);
    chk("perf_stall_rst", pt1, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
